projectile_flight_ctrl: RTL and testbench

Sequences one projectile shot for the artillery game: aim selection, launch, per-frame physics stepping, hit/miss detection and scoring. It replaces free-running closed-form position math with incremental integer integration driven by a frame tick. Its outputs (projectile position, active flag, hit flash, score) feed vga_bitchange drawing and the seven-segment score display.

---
 rtl/proj_pkg.sv | 34 +++
 rtl/tick_gen.sv | 26 ++
 rtl/projectile_flight_ctrl.sv | 157 +++++++++++++++
 tb/tb_projectile_flight_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared encodings and screen constants for the projectile shot sequencer.
// Velocity presets are selected by aim index; vx is in pixels/step and vy is positive upward.
package proj_pkg;

  typedef enum logic [1:0] {
    S_AIM    = 2'd0,
    S_FLIGHT = 2'd1,
    S_HIT    = 2'd2,
    S_MISS   = 2'd3
  } state_t;

  localparam logic [9:0] X_INIT     = 10'd213;
  localparam logic [9:0] Y_INIT     = 10'd472;
  localparam logic [9:0] GROUND_Y   = 10'd476;
  localparam logic [9:0] RIGHT_EDGE = 10'd775;
  localparam logic [9:0] TARGET_Y   = 10'd470;

  typedef struct packed {
    logic [5:0] vx;
    logic [7:0] vy;
  } vel_t;

  function automatic vel_t vel_lookup(input logic [1:0] idx);
    vel_t v;
    case (idx)
      2'd0:    v = '{vx: 6'd40, vy: 8'd8};
      2'd1:    v = '{vx: 6'd16, vy: 8'd16};
      2'd2:    v = '{vx: 6'd12, vy: 8'd20};
      default: v = '{vx: 6'd8,  vy: 8'd24};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Physics frame tick: counts 0..TICK_DIV-1 while enabled and pulses on the wrap cycle.
// Holding en low clears the count, so the first tick lands TICK_DIV cycles after enable.
module tick_gen #(
  parameter int TICK_DIV = 1666667
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(TICK_DIV - 1));
  assign tick = en && wrap;

  always_ff @(posedge clk) begin
    if (reset || !en) cnt <= '0;
    else if (wrap)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/projectile_flight_ctrl.sv
// One artillery shot: aim select, launch, per-tick integration, hit/miss detect, scoring.
// Optional wind input is enabled by defining PROJ_WIND_EN.
module projectile_flight_ctrl
  import proj_pkg::*;
#(
  parameter int TICK_DIV  = 1666667,
  parameter int HIT_HOLD  = 60,
  parameter int MISS_HOLD = 30,
  parameter int GRAV      = 1
) (
  input  logic              clk,
  input  logic              reset,
  // fire/aim_* are single-cycle pulses with no back-pressure; ignored unless state is AIM.
  input  logic              fire,
  input  logic              aim_up,
  input  logic              aim_down,
  input  logic [9:0]        target_x_lo,
  input  logic [9:0]        target_x_hi,
  output logic [9:0]        proj_x,
  output logic [9:0]        proj_y,
  output logic              proj_active,
  output logic              hit_flash,
  output logic [1:0]        aim_idx,
  output logic [15:0]       score,
  output logic [1:0]        state
`ifdef PROJ_WIND_EN
  ,
  input  logic signed [3:0] wind
`endif
);

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [5:0]         vx_q, vx_d;
  logic signed [7:0]  vy_q, vy_d;
  logic [7:0]         hold_q, hold_d;
  logic [1:0]         aim_q, aim_d;
  logic [15:0]        score_q, score_d;
  logic               active_q, flash_q;
  logic               tick;
  vel_t               vel;
  logic signed [10:0] x_n, y_n;
  logic               hit, miss;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != S_AIM),
    .tick  (tick)
  );

  assign vel = vel_lookup(aim_q);
  assign x_n = signed'({1'b0, x_q}) + signed'({5'b0, vx_q});
  assign y_n = signed'({1'b0, y_q}) - {{3{vy_q[7]}}, vy_q};

  // x_n never goes negative, so the sign bit is always clear in these compares.
  assign hit  = (x_n >= signed'({1'b0, target_x_lo})) && (x_n <= signed'({1'b0, target_x_hi}))
             && (y_n >= signed'({1'b0, TARGET_Y}));
  assign miss = (x_n >= signed'({1'b0, RIGHT_EDGE})) || (y_n > signed'({1'b0, GROUND_Y}));

`ifdef PROJ_WIND_EN
  logic signed [7:0] vx_sum;
  assign vx_sum = signed'({2'b00, vx_q}) + {{4{wind[3]}}, wind};
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    hold_d  = hold_q;
    aim_d   = aim_q;
    score_d = score_q;
    case (state_q)
      S_AIM: begin
        if (fire) begin
          state_d = S_FLIGHT;
          x_d     = X_INIT;
          y_d     = Y_INIT;
          vx_d    = vel.vx;
          vy_d    = signed'(vel.vy);
        end else if (aim_up && !aim_down && aim_q != 2'd3) begin
          aim_d = aim_q + 2'd1;
        end else if (aim_down && !aim_up && aim_q != 2'd0) begin
          aim_d = aim_q - 2'd1;
        end
      end
      S_FLIGHT: begin
        if (tick) begin
          x_d    = x_n[9:0];
          y_d    = y_n[10] ? 10'd0 : y_n[9:0];
          vy_d   = vy_q - 8'(GRAV);
          hold_d = '0;
`ifdef PROJ_WIND_EN
          if (vx_sum < 0)        vx_d = 6'd0;
          else if (vx_sum > 63)  vx_d = 6'd63;
          else                   vx_d = vx_sum[5:0];
`endif
          if (hit) begin
            state_d = S_HIT;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end else if (miss) begin
            state_d = S_MISS;
          end
        end
      end
      S_HIT, S_MISS: begin
        if (tick) begin
          if (hold_q == ((state_q == S_HIT) ? 8'(HIT_HOLD - 1) : 8'(MISS_HOLD - 1))) begin
            state_d = S_AIM;
            x_d     = X_INIT;
            y_d     = Y_INIT;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: state_d = S_AIM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_AIM;
      x_q      <= X_INIT;
      y_q      <= Y_INIT;
      vx_q     <= '0;
      vy_q     <= '0;
      hold_q   <= '0;
      aim_q    <= 2'd1;
      score_q  <= '0;
      active_q <= 1'b0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      hold_q   <= hold_d;
      aim_q    <= aim_d;
      score_q  <= score_d;
      active_q <= (state_d == S_FLIGHT);
      flash_q  <= (state_d == S_HIT);
    end
  end

  assign proj_x      = x_q;
  assign proj_y      = y_q;
  assign proj_active = active_q;
  assign hit_flash   = flash_q;
  assign aim_idx     = aim_q;
  assign score       = score_q;
  assign state       = state_q;

endmodule

// File: tb/tb_projectile_flight_ctrl.sv
// Directed bench for projectile_flight_ctrl with TICK_DIV=4 (one physics step every 4 clocks).
// Expected positions are hand-derived from x=213+vx*k, y=472-sum(vy-j) over the k steps.
module tb_projectile_flight_ctrl;

  logic        clk = 1'b0;
  logic        reset, fire, aim_up, aim_down;
  logic [9:0]  target_x_lo, target_x_hi;
  logic [9:0]  proj_x, proj_y;
  logic        proj_active, hit_flash;
  logic [1:0]  aim_idx, state;
  logic [15:0] score;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  projectile_flight_ctrl #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fire        (fire),
    .aim_up      (aim_up),
    .aim_down    (aim_down),
    .target_x_lo (target_x_lo),
    .target_x_hi (target_x_hi),
    .proj_x      (proj_x),
    .proj_y      (proj_y),
    .proj_active (proj_active),
    .hit_flash   (hit_flash),
    .aim_idx     (aim_idx),
    .score       (score),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic up, input logic down, input logic f);
    @(negedge clk);
    aim_up = up; aim_down = down; fire = f;
    @(negedge clk);
    aim_up = 1'b0; aim_down = 1'b0; fire = 1'b0;
  endtask

  task automatic wait_leave(input logic [1:0] st, input int start, output int cnt);
    cnt = start;
    while (state == st && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0; aim_up = 1'b0; aim_down = 1'b0;
    target_x_lo = 10'd0; target_x_hi = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_x", proj_x, 213);
    check("rst_y", proj_y, 472);
    check("rst_aim", aim_idx, 1);
    check("rst_score", score, 0);
    check("rst_active", proj_active, 0);
    check("rst_flash", hit_flash, 0);
    reset = 1'b0;

    // Aim selection and saturation
    pulse(1, 0, 0); check("aim_up1", aim_idx, 2);
    pulse(1, 0, 0); check("aim_up2", aim_idx, 3);
    pulse(1, 0, 0); check("aim_up_sat", aim_idx, 3);
    pulse(1, 1, 0); check("aim_both", aim_idx, 3);
    pulse(0, 1, 0); check("aim_dn1", aim_idx, 2);
    repeat (3) pulse(0, 1, 0);
    check("aim_dn_sat", aim_idx, 0);

    // Hit on the 33rd tick with preset 1
    pulse(1, 0, 0); check("aim_to1", aim_idx, 1);
    target_x_lo = 10'd736; target_x_hi = 10'd745;
    pulse(0, 0, 1);
    check("t3_state", state, 1);
    check("t3_active", proj_active, 1);
    check("t3_x0", proj_x, 213);
    pulse(1, 0, 0);
    check("t3_aim_locked", aim_idx, 1);
    wait_leave(1, 2, n);
    check("t3_hit_cycles", n, 132);
    check("t3_hit_state", state, 2);
    check("t3_hit_x", proj_x, 741);
    check("t3_hit_y", proj_y, 472);
    check("t3_flash", hit_flash, 1);
    check("t3_active_off", proj_active, 0);
    check("t3_score", score, 1);
    wait_leave(2, 0, n);
    check("t3_hold_cycles", n, 240);
    check("t3_aim_state", state, 0);
    check("t3_x_home", proj_x, 213);
    check("t3_y_home", proj_y, 472);
    check("t3_flash_off", hit_flash, 0);

    // Near pass then ground miss on the 34th tick
    target_x_lo = 10'd650; target_x_hi = 10'd675;
    pulse(0, 0, 1);
    repeat (112) @(negedge clk);
    check("t4_pass_state", state, 1);
    check("t4_pass_x", proj_x, 661);
    check("t4_pass_y", proj_y, 402);
    wait_leave(1, 112, n);
    check("t4_miss_cycles", n, 136);
    check("t4_miss_state", state, 3);
    check("t4_miss_x", proj_x, 757);
    check("t4_miss_y", proj_y, 489);
    check("t4_score", score, 1);
    check("t4_flash", hit_flash, 0);
    wait_leave(3, 0, n);
    check("t4_hold_cycles", n, 120);
    check("t4_aim_state", state, 0);

    // Edge miss with preset 0; aim pulse alongside fire is ignored
    pulse(0, 1, 0); check("t5_aim0", aim_idx, 0);
    target_x_lo = 10'd0; target_x_hi = 10'd0;
    pulse(1, 0, 1);
    check("t5_aim_fire", aim_idx, 0);
    check("t5_state", state, 1);
    wait_leave(1, 0, n);
    check("t5_miss_cycles", n, 60);
    check("t5_miss_state", state, 3);
    check("t5_miss_x", proj_x, 813);
    check("t5_miss_y", proj_y, 457);
    wait_leave(3, 0, n);
    check("t5_hold_cycles", n, 120);

    // Second hit; fire during HIT is ignored
    pulse(1, 0, 0);
    target_x_lo = 10'd736; target_x_hi = 10'd745;
    pulse(0, 0, 1);
    wait_leave(1, 0, n);
    check("t6_hit_cycles", n, 132);
    check("t6_score2", score, 2);
    pulse(0, 0, 1);
    check("t6_fire_in_hit", state, 2);
    check("t6_score_hold", score, 2);
    wait_leave(2, 2, n);
    check("t6_hold_cycles", n, 240);

    // Reset mid-flight at tick 10
    pulse(0, 0, 1);
    repeat (40) @(negedge clk);
    check("t6_t10_x", proj_x, 373);
    check("t6_t10_y", proj_y, 357);
    check("t6_t10_state", state, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_state", state, 0);
    check("t6_rst_score", score, 0);
    check("t6_rst_x", proj_x, 213);
    check("t6_rst_y", proj_y, 472);
    check("t6_rst_aim", aim_idx, 1);
    check("t6_rst_active", proj_active, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
